// File: rtl/dbus_timer_pkg.sv
// Shared constants and helpers for the data-bus timer responder:
// register indices, CTRL/STATUS bit positions, reset values and the
// byte-lane merge used by every writable register.
package dbus_timer_pkg;

  // Register indices (iAddress[4:2]).
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_COUNT    = 3'd1;
  localparam logic [2:0] REG_COMPARE  = 3'd2;
  localparam logic [2:0] REG_STATUS   = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;
  localparam logic [2:0] REG_CAPTURE  = 3'd5;

  // CTRL bit positions.
  localparam int CTRL_EN         = 0;
  localparam int CTRL_AUTORELOAD = 1;
  localparam int CTRL_IRQEN      = 2;
  localparam int CTRL_W          = 3;

  // STATUS bit positions (all write-1-to-clear).
  localparam int STAT_MATCH = 0;
  localparam int STAT_OVF   = 1;
  localparam int STAT_CAPF  = 2;

  // Reset values.
  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;
  localparam logic [31:0] COUNT_MAX   = 32'hFFFF_FFFF;

  // Replace the byte lanes of oldWord whose enable bit is set with newWord.
  function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                             input logic [31:0] newWord,
                                             input logic [3:0]  byteEn);
    logic [31:0] merged;
    merged = oldWord;
    for (int lane = 0; lane < 4; lane++) begin
      if (byteEn[lane]) merged[8*lane +: 8] = newWord[8*lane +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the bus timer: counts 0..iReload while enabled and
// emits a one-cycle tick on the cycle it sits at iReload.
module timer_prescaler #(
  parameter int W = 16
) (
  input  logic         iCLK,
  input  logic         iRST,
  input  logic         iEnable,
  input  logic         iClear,
  input  logic [W-1:0] iReload,
  output logic         oTick
);

  logic [W-1:0] preCount;
  logic         atReload;

  assign atReload = (preCount == iReload);
  // Reset suppresses the tick so an aborted cycle never advances COUNT.
  assign oTick    = iEnable && atReload && !iRST;

  // Prescale counter: held at 0 when disabled or cleared, wraps at reload.
  always_ff @(posedge iCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (iRST) begin
      preCount <= '0;
    end else if (!iEnable || iClear || atReload) begin
      preCount <= '0;
    end else begin
      preCount <= preCount + W'(1);
    end
  end

endmodule

// File: rtl/dbus_timer_responder.sv
// Memory-mapped timer/counter on the processor data bus (Dw* responder).
// 32-byte window at BASE_ADDR: CTRL, COUNT, COMPARE, STATUS, PRESCALE,
// CAPTURE. Reads are combinational; writes are byte-lane masked.
// Optional input capture is enabled by defining TIMER_CAPTURE_EN.
module dbus_timer_responder
  import dbus_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hFF20_0000,
  parameter int          PRESCALE_W = 16
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iReadEnable,
  input  logic        iWriteEnable,
  input  logic [3:0]  iByteEnable,
  input  logic [31:0] iAddress,
  input  logic [31:0] iWriteData,
  output logic [31:0] oReadData,
  output logic        oSelected,
  output logic        oIRQ
`ifdef TIMER_CAPTURE_EN
  ,
  input  logic        iCapture
`endif
);

  // Decode.
  logic       inWindow;
  logic [2:0] regIdx;
  logic       wrStrobe;
  logic       wrCtrl, wrCount, wrCompare, wrStatus, wrPrescale;

  // Architectural state.
  logic [CTRL_W-1:0]     ctrlReg;
  logic [31:0]           countReg;
  logic [31:0]           compareReg;
  logic [PRESCALE_W-1:0] prescaleReg;
  logic                  matchFlag;
  logic                  ovfFlag;
  logic [31:0]           captureReg;
  logic                  capfFlag;

  // Next-state values.
  logic [31:0]           ctrlMerged;
  logic [31:0]           prescaleMerged;
  logic [CTRL_W-1:0]     ctrlNext;
  logic [31:0]           countNext;
  logic [31:0]           compareNext;
  logic [PRESCALE_W-1:0] prescaleNext;
  logic                  matchNext;
  logic                  ovfNext;

  logic        tick;
  logic        isMatch;
  logic        ovfSet;
  logic        w1cMatch, w1cOvf;
  logic [31:0] countIncr;
  logic [31:0] statusWord;
  logic [31:0] readMux;
  logic        unusedBits;

  assign inWindow   = (iAddress[31:5] == BASE_ADDR[31:5]);
  assign regIdx     = iAddress[4:2];
  assign wrStrobe   = inWindow && iWriteEnable && !iRST;
  assign wrCtrl     = wrStrobe && (regIdx == REG_CTRL);
  assign wrCount    = wrStrobe && (regIdx == REG_COUNT);
  assign wrCompare  = wrStrobe && (regIdx == REG_COMPARE);
  assign wrStatus   = wrStrobe && (regIdx == REG_STATUS);
  assign wrPrescale = wrStrobe && (regIdx == REG_PRESCALE);

  assign w1cMatch = wrStatus && iByteEnable[0] && iWriteData[STAT_MATCH];
  assign w1cOvf   = wrStatus && iByteEnable[0] && iWriteData[STAT_OVF];

  // Address bits [1:0] are ignored; merged words are only partly stored.
  assign unusedBits = ^{iAddress[1:0], ctrlMerged, prescaleMerged};

  timer_prescaler #(
    .W(PRESCALE_W)
  ) uPrescaler (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iEnable (ctrlReg[CTRL_EN]),
    .iClear  (wrPrescale),
    .iReload (prescaleReg),
    .oTick   (tick)
  );

  // Next-state for CTRL/COUNT/COMPARE/PRESCALE/STATUS; CPU write lanes win
  // over the tick update, a new match wins over a same-cycle W1C.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned and no latch is inferred.
    ctrlMerged     = mergeBytes(32'(ctrlReg), iWriteData, iByteEnable);
    prescaleMerged = mergeBytes(32'(prescaleReg), iWriteData, iByteEnable);
    ctrlNext       = ctrlReg;
    compareNext    = compareReg;
    prescaleNext   = prescaleReg;
    countIncr      = countReg + 32'd1;
    isMatch        = tick && (countReg == compareReg);
    ovfSet         = 1'b0;
    countNext      = countReg;

    if (tick) begin
      if (isMatch && ctrlReg[CTRL_AUTORELOAD]) begin
        countNext = '0;
      end else begin
        countNext = countIncr;
        ovfSet    = (countReg == COUNT_MAX);
      end
    end

    if (wrCount)    countNext    = mergeBytes(countNext, iWriteData, iByteEnable);
    if (wrCompare)  compareNext  = mergeBytes(compareReg, iWriteData, iByteEnable);
    if (wrCtrl)     ctrlNext     = ctrlMerged[CTRL_W-1:0];
    if (wrPrescale) prescaleNext = prescaleMerged[PRESCALE_W-1:0];

    matchNext = (matchFlag && !w1cMatch) || isMatch;
    ovfNext   = (ovfFlag && !w1cOvf) || ovfSet;
  end

  // Register file update.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      ctrlReg     <= '0;
      countReg    <= '0;
      compareReg  <= COMPARE_RST;
      prescaleReg <= '0;
      matchFlag   <= 1'b0;
      ovfFlag     <= 1'b0;
    end else begin
      ctrlReg     <= ctrlNext;
      countReg    <= countNext;
      compareReg  <= compareNext;
      prescaleReg <= prescaleNext;
      matchFlag   <= matchNext;
      ovfFlag     <= ovfNext;
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic capSync1, capSync2, capPrev;
  logic capRise;
  logic w1cCapf;

  assign capRise = capSync2 && !capPrev;
  assign w1cCapf = wrStatus && iByteEnable[0] && iWriteData[STAT_CAPF];

  // Two-flop synchronizer plus a delay flop for rising-edge detection.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      capSync1 <= 1'b0;
      capSync2 <= 1'b0;
      capPrev  <= 1'b0;
    end else begin
      capSync1 <= iCapture;
      capSync2 <= capSync1;
      capPrev  <= capSync2;
    end
  end

  // Latch the pre-increment COUNT on a detected edge and flag it.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      captureReg <= '0;
      capfFlag   <= 1'b0;
    end else begin
      if (capRise) captureReg <= countReg;
      capfFlag <= (capfFlag && !w1cCapf) || capRise;
    end
  end
`else
  assign captureReg = '0;
  assign capfFlag   = 1'b0;
`endif

  // Combinational read mux; unselected or non-read cycles drive zero.
  always_comb begin
    statusWord             = '0;
    statusWord[STAT_MATCH] = matchFlag;
    statusWord[STAT_OVF]   = ovfFlag;
    statusWord[STAT_CAPF]  = capfFlag;
    readMux                = '0;
    case (regIdx)
      REG_CTRL:     readMux = 32'(ctrlReg);
      REG_COUNT:    readMux = countReg;
      REG_COMPARE:  readMux = compareReg;
      REG_STATUS:   readMux = statusWord;
      REG_PRESCALE: readMux = 32'(prescaleReg);
      REG_CAPTURE:  readMux = captureReg;
      default:      readMux = '0;
    endcase
  end

  assign oSelected = inWindow && (iReadEnable || iWriteEnable) && !iRST;
  assign oReadData = (inWindow && iReadEnable && !iRST) ? readMux : 32'h0;
  assign oIRQ      = ctrlReg[CTRL_IRQEN] && matchFlag;

endmodule

// File: tb/tb_dbus_timer_responder.sv
// Directed bench for dbus_timer_responder: expected values are pushed to
// a scoreboard queue when stimulus is driven and popped at each sample.
module tb_dbus_timer_responder;

  localparam logic [31:0] BASE = 32'hFF20_0000;

  logic        iCLK;
  logic        iRST;
  logic        iReadEnable;
  logic        iWriteEnable;
  logic [3:0]  iByteEnable;
  logic [31:0] iAddress;
  logic [31:0] iWriteData;
  logic [31:0] oReadData;
  logic        oSelected;
  logic        oIRQ;
  logic        iCapture;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sbEntry_t;

  sbEntry_t sbQ[$];
  int       testsRun = 0;
  int       testsFailed = 0;

  dbus_timer_responder dut (
    .iCLK         (iCLK),
    .iRST         (iRST),
    .iReadEnable  (iReadEnable),
    .iWriteEnable (iWriteEnable),
    .iByteEnable  (iByteEnable),
    .iAddress     (iAddress),
    .iWriteData   (iWriteData),
    .oReadData    (oReadData),
    .oSelected    (oSelected),
    .oIRQ         (oIRQ)
`ifdef TIMER_CAPTURE_EN
    ,
    .iCapture     (iCapture)
`endif
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic expectVal(input string tag, input logic [31:0] exp);
    sbQ.push_back('{tag, exp});
  endtask

  task automatic check(input logic [31:0] observed);
    sbEntry_t e;
    testsRun++;
    if (sbQ.size() == 0) begin
      testsFailed++;
      $error("FAIL scoreboard_empty: observed %h required an entry", observed);
    end else begin
      e = sbQ.pop_front();
      assert (observed === e.exp) else begin
        testsFailed++;
        $error("FAIL %s: observed %h required %h", e.tag, observed, e.exp);
      end
    end
  endtask

  task automatic idle();
    @(posedge iCLK);
    #1;
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be);
    iAddress     = addr;
    iWriteData   = data;
    iByteEnable  = be;
    iWriteEnable = 1'b1;
    @(posedge iCLK);
    #1;
    iWriteEnable = 1'b0;
    iByteEnable  = 4'h0;
  endtask

  task automatic busRead(input logic [31:0] addr, input logic [31:0] exp,
                         input string tag);
    iAddress    = addr;
    iByteEnable = 4'hF;
    iReadEnable = 1'b1;
    expectVal(tag, exp);
    @(negedge iCLK);
    check(oReadData);
    @(posedge iCLK);
    #1;
    iReadEnable = 1'b0;
    iByteEnable = 4'h0;
  endtask

  initial begin
    iRST         = 1'b1;
    iReadEnable  = 1'b0;
    iWriteEnable = 1'b0;
    iByteEnable  = 4'h0;
    iAddress     = 32'h0;
    iWriteData   = 32'h0;
    iCapture     = 1'b0;
    repeat (3) @(posedge iCLK);
    #1;
    iRST = 1'b0;

    // Reset state.
    busRead(BASE + 32'h08, 32'hFFFF_FFFF, "rst_compare");
    busRead(BASE + 32'h00, 32'h0, "rst_ctrl");
    busRead(BASE + 32'h04, 32'h0, "rst_count");
    busRead(BASE + 32'h0C, 32'h0, "rst_status");
    busRead(BASE + 32'h10, 32'h0, "rst_prescale");
    expectVal("rst_irq", 32'h0);
    @(negedge iCLK);
    check(32'(oIRQ));
    idle();

    // Unselected address: no data, no select.
    iAddress    = 32'h1001_0000;
    iReadEnable = 1'b1;
    expectVal("unsel_data", 32'h0);
    expectVal("unsel_sel", 32'h0);
    @(negedge iCLK);
    check(oReadData);
    check(32'(oSelected));
    idle();
    // Selected read asserts oSelected.
    iAddress = BASE + 32'h08;
    expectVal("sel_flag", 32'h1);
    @(negedge iCLK);
    check(32'(oSelected));
    idle();
    iReadEnable = 1'b0;

    // Byte-lane writes.
    busWrite(BASE + 32'h04, 32'hAABB_CCDD, 4'b1111);
    busWrite(BASE + 32'h04, 32'h0000_0011, 4'b0001);
    busRead(BASE + 32'h04, 32'hAABB_CC11, "byte_write");
    busRead(BASE + 32'h06, 32'hAABB_CC11, "addr_lsb_ignored");
    busWrite(BASE + 32'h08, 32'h1234_5678, 4'b0110);
    busRead(BASE + 32'h08, 32'hFF34_56FF, "compare_lanes");
    busWrite(BASE + 32'h18, 32'hDEAD_BEEF, 4'b1111);
    busRead(BASE + 32'h18, 32'h0, "reserved_reads_zero");
    busWrite(BASE + 32'h00, 32'hFFFF_FFF8, 4'b1111);
    busRead(BASE + 32'h00, 32'h0, "ctrl_upper_bits_zero");

    // Match/IRQ timing: PRESCALE=3, COMPARE=2, CTRL=EN|AUTORELOAD|IRQEN.
    busWrite(BASE + 32'h04, 32'h0, 4'b1111);
    busWrite(BASE + 32'h10, 32'h3, 4'b1111);
    busWrite(BASE + 32'h08, 32'h2, 4'b1111);
    busWrite(BASE + 32'h00, 32'h7, 4'b1111);
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) @(posedge iCLK);
      expectVal($sformatf("irq_cycle_%0d", k), (k == 12) ? 32'h1 : 32'h0);
      @(negedge iCLK);
      check(32'(oIRQ));
    end
    idle();
    busRead(BASE + 32'h04, 32'h0, "autoreload_count");
    busRead(BASE + 32'h0C, 32'h1, "match_status");
    expectVal("irq_before_w1c", 32'h1);
    @(negedge iCLK);
    check(32'(oIRQ));
    busWrite(BASE + 32'h0C, 32'h1, 4'b0001);
    expectVal("irq_after_w1c", 32'h0);
    @(negedge iCLK);
    check(32'(oIRQ));
    idle();
    busWrite(BASE + 32'h00, 32'h0, 4'b1111);
    busWrite(BASE + 32'h0C, 32'h3, 4'b0001);

    // Overflow without autoreload, tick every cycle.
    busWrite(BASE + 32'h08, 32'h0000_1000, 4'b1111);
    busWrite(BASE + 32'h10, 32'h0, 4'b1111);
    busWrite(BASE + 32'h04, 32'hFFFF_FFFE, 4'b1111);
    busWrite(BASE + 32'h00, 32'h1, 4'b1111);
    idle();
    idle();
    busRead(BASE + 32'h04, 32'h0, "ovf_wrap_count");
    busRead(BASE + 32'h0C, 32'h2, "ovf_status");
    busWrite(BASE + 32'h00, 32'h0, 4'b1111);
    busWrite(BASE + 32'h0C, 32'h3, 4'b0001);
    busRead(BASE + 32'h0C, 32'h0, "status_cleared");

    // CPU write to COUNT in tick cycles.
    busWrite(BASE + 32'h00, 32'h1, 4'b1111);
    busWrite(BASE + 32'h04, 32'h0000_0100, 4'b1111);
    busRead(BASE + 32'h04, 32'h0000_0100, "write_wins_tick");
    busWrite(BASE + 32'h04, 32'h0000_0055, 4'b0001);
    busRead(BASE + 32'h04, 32'h0000_0155, "lane_write_plus_incr");
    busWrite(BASE + 32'h00, 32'h0, 4'b1111);

    // W1C of MATCH in the match cycle: set wins.
    busWrite(BASE + 32'h08, 32'h5, 4'b1111);
    busWrite(BASE + 32'h04, 32'h5, 4'b1111);
    busWrite(BASE + 32'h00, 32'h3, 4'b1111);
    busWrite(BASE + 32'h0C, 32'h1, 4'b0001);
    busRead(BASE + 32'h0C, 32'h1, "match_set_wins_w1c");
    busRead(BASE + 32'h04, 32'h1, "autoreload_after_match");
    busWrite(BASE + 32'h00, 32'h0, 4'b1111);
    busWrite(BASE + 32'h0C, 32'h7, 4'b0001);

`ifdef TIMER_CAPTURE_EN
    // Capture: edge seen 3 edges after iCapture rises.
    busWrite(BASE + 32'h00, 32'h1, 4'b1111);
    iCapture = 1'b1;
    busWrite(BASE + 32'h04, 32'h0000_1000, 4'b1111);
    idle();
    idle();
    iCapture = 1'b0;
    busWrite(BASE + 32'h00, 32'h0, 4'b1111);
    busRead(BASE + 32'h14, 32'h0000_1001, "capture_value");
    busRead(BASE + 32'h0C, 32'h4, "capf_status");
    busWrite(BASE + 32'h0C, 32'h4, 4'b0001);
    busRead(BASE + 32'h0C, 32'h0, "capf_cleared");
`else
    busRead(BASE + 32'h14, 32'h0, "capture_absent");
    busRead(BASE + 32'h0C, 32'h0, "capf_absent");
`endif

    // Reset mid-count restores reset values.
    busWrite(BASE + 32'h08, 32'h0000_1234, 4'b1111);
    busWrite(BASE + 32'h00, 32'h1, 4'b1111);
    idle();
    iRST = 1'b1;
    idle();
    iRST = 1'b0;
    busRead(BASE + 32'h08, 32'hFFFF_FFFF, "mid_reset_compare");
    busRead(BASE + 32'h04, 32'h0, "mid_reset_count");
    busRead(BASE + 32'h00, 32'h0, "mid_reset_ctrl");

    if (sbQ.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("FAIL scoreboard_leftover: observed %0d entries required 0", sbQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
